ex_stage_md: RTL and testbench

- Parametrised next-generation execute stage.
- Latches one instruction from ID with a valid/allow_in handshake and computes add/multiply results in one cycle.
- Runs an iterative multi-cycle divider that stalls the stage until the result is ready.
- Drives the data SRAM with size-aware byte enables and lane-aligned store data, then forwards the result to MEM.

---
 rtl/ex_stage_md.sv | 202 ++++++++++++++++++++
 tb/tb_ex_stage_md.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_md.sv
// Execute stage: single-cycle add/multiply, iterative restoring divider, data SRAM store/load drive.
// Optional misaligned-access exception via `define EX_ALE_EN.
module ex_stage_md #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 5
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                ds_to_es_valid,
    output logic                es_allow_in,
    input  logic                ms_allow_in,
    output logic                es_to_ms_valid,
    input  logic [31:0]         ds_pc,
    input  logic [DATA_W-1:0]   ds_src1,
    input  logic [DATA_W-1:0]   ds_src2,
    input  logic [DATA_W-1:0]   ds_st_data,
    input  logic [3:0]          ds_op,
    input  logic                ds_mem_we,
    input  logic                ds_res_from_mem,
    input  logic [1:0]          ds_mem_size,
    input  logic [DEST_W-1:0]   ds_dest,
    input  logic                ds_gr_we,
    output logic [31:0]         es_to_ms_pc,
    output logic [DATA_W-1:0]   es_to_ms_result,
`ifdef EX_ALE_EN
    output logic                es_ex_ale,
`endif
    output logic                es_to_ms_res_from_mem,
    output logic [DEST_W-1:0]   es_to_ms_dest,
    output logic                es_to_ms_gr_we,
    output logic                data_sram_en,
    output logic [DATA_W/8-1:0] data_sram_we,
    output logic [31:0]         data_sram_addr,
    output logic [DATA_W-1:0]   data_sram_wdata
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2;
    localparam logic [3:0] OP_MUL = 4'd1, OP_MULH = 4'd2, OP_MULHU = 4'd3;

    typedef struct packed {
        logic [31:0]       pc;
        logic [DATA_W-1:0] src1;
        logic [DATA_W-1:0] src2;
        logic [DATA_W-1:0] st_data;
        logic [3:0]        op;
        logic              mem_we;
        logic              res_from_mem;
        logic [1:0]        mem_size;
        logic [DEST_W-1:0] dest;
        logic              gr_we;
    } inst_t;

    inst_t             inst_q, inst_d;
    logic              es_valid_q, es_valid_d;
    logic [1:0]        div_state_q, div_state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] quo_q, quo_d, rem_q, rem_d, dvsr_q, dvsr_d;
    logic              q_neg_q, q_neg_d, r_neg_q, r_neg_d, dz_q, dz_d;

    logic              is_div, div_sgn, es_ready_go, sgn_mul;
    logic [DATA_W-1:0] alu_add, div_quo, div_rem;
    logic [DATA_W:0]   r_sh, diff;
    logic [2*DATA_W-1:0] a_ext, b_ext, prod;
    logic [NB-1:0]     lane_mask;
    int                off, sz_bytes, aoff;

    assign is_div         = (inst_q.op[3:2] == 2'b01);
    assign div_sgn        = ~inst_q.op[0];
    assign es_ready_go    = ~is_div | (div_state_q == S_DONE);
    assign es_allow_in    = ~es_valid_q | (es_ready_go & ms_allow_in);
    assign es_to_ms_valid = es_valid_q & es_ready_go;

    always_comb begin
        es_valid_d = es_valid_q;
        inst_d     = inst_q;
        if (ds_to_es_valid && es_allow_in) begin
            es_valid_d = 1'b1;
            inst_d     = '{ds_pc, ds_src1, ds_src2, ds_st_data, ds_op, ds_mem_we,
                           ds_res_from_mem, ds_mem_size, ds_dest, ds_gr_we};
        end else if (es_allow_in) begin
            es_valid_d = 1'b0;
        end
    end

    // Restoring step: the partial remainder never exceeds the divisor, so DATA_W+1 bits suffice.
    assign r_sh = {rem_q, quo_q[DATA_W-1]};
    assign diff = r_sh - {1'b0, dvsr_q};

    always_comb begin
        div_state_d = div_state_q;
        cnt_d       = cnt_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dvsr_d      = dvsr_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        dz_d        = dz_q;
        case (div_state_q)
            S_IDLE: if (es_valid_q && is_div) begin
                div_state_d = S_BUSY;
                cnt_d       = CNT_W'(DATA_W);
                quo_d       = (div_sgn && inst_q.src1[DATA_W-1]) ? -inst_q.src1 : inst_q.src1;
                dvsr_d      = (div_sgn && inst_q.src2[DATA_W-1]) ? -inst_q.src2 : inst_q.src2;
                rem_d       = '0;
                q_neg_d     = div_sgn & (inst_q.src1[DATA_W-1] ^ inst_q.src2[DATA_W-1]);
                r_neg_d     = div_sgn & inst_q.src1[DATA_W-1];
                dz_d        = (inst_q.src2 == '0);
            end
            S_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (!diff[DATA_W]) begin
                    rem_d = diff[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], 1'b1};
                end else begin
                    rem_d = r_sh[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], 1'b0};
                end
                if (cnt_q == CNT_W'(1)) div_state_d = S_DONE;
            end
            S_DONE: if (es_to_ms_valid && ms_allow_in) div_state_d = S_IDLE;
            default: div_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_valid_q  <= 1'b0;
            inst_q      <= '0;
            div_state_q <= S_IDLE;
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvsr_q      <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            es_valid_q  <= es_valid_d;
            inst_q      <= inst_d;
            div_state_q <= div_state_d;
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dvsr_q      <= dvsr_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            dz_q        <= dz_d;
        end
    end

    assign div_quo = dz_q ? '1 : (q_neg_q ? -quo_q : quo_q);
    assign div_rem = r_neg_q ? -rem_q : rem_q;

    // One 2W-bit multiplier; sign-extending only for MULH gives both signed and unsigned products.
    assign alu_add = inst_q.src1 + inst_q.src2;
    assign sgn_mul = (inst_q.op == OP_MULH);
    assign a_ext   = {{DATA_W{sgn_mul & inst_q.src1[DATA_W-1]}}, inst_q.src1};
    assign b_ext   = {{DATA_W{sgn_mul & inst_q.src2[DATA_W-1]}}, inst_q.src2};
    assign prod    = a_ext * b_ext;

    always_comb begin
        case (inst_q.op)
            OP_MUL:                       es_to_ms_result = prod[DATA_W-1:0];
            OP_MULH, OP_MULHU:            es_to_ms_result = prod[2*DATA_W-1:DATA_W];
            4'd4, 4'd5:                   es_to_ms_result = div_quo;
            4'd6, 4'd7:                   es_to_ms_result = div_rem;
            default:                      es_to_ms_result = alu_add;
        endcase
    end

    always_comb begin
        off      = {{(32-OFF_W){1'b0}}, alu_add[OFF_W-1:0]};
        sz_bytes = 1 << inst_q.mem_size;
        aoff     = off & ~(sz_bytes - 1);
        for (int i = 0; i < NB; i++) lane_mask[i] = (i >= aoff) && (i < aoff + sz_bytes);
        case (inst_q.mem_size)
            2'd0:    data_sram_wdata = {NB{inst_q.st_data[7:0]}};
            2'd1:    data_sram_wdata = {(NB/2){inst_q.st_data[15:0]}};
            2'd2:    data_sram_wdata = {(NB/4){inst_q.st_data[31:0]}};
            default: data_sram_wdata = inst_q.st_data;
        endcase
    end

    assign data_sram_addr        = alu_add[31:0];
    assign es_to_ms_pc           = inst_q.pc;
    assign es_to_ms_res_from_mem = inst_q.res_from_mem;
    assign es_to_ms_dest         = inst_q.dest;
    assign es_to_ms_gr_we        = inst_q.gr_we;

`ifdef EX_ALE_EN
    logic misaligned;
    assign misaligned   = (off & (sz_bytes - 1)) != 0;
    assign es_ex_ale    = es_to_ms_valid & (inst_q.mem_we | inst_q.res_from_mem) & misaligned;
    assign data_sram_en = es_valid_q & ~(inst_q.res_from_mem & misaligned);
    assign data_sram_we = (es_valid_q && inst_q.mem_we && ms_allow_in && !misaligned) ? lane_mask : '0;
`else
    assign data_sram_en = es_valid_q;
    assign data_sram_we = (es_valid_q && inst_q.mem_we && ms_allow_in) ? lane_mask : '0;
`endif
endmodule

// File: tb/tb_ex_stage_md.sv
// Bench for ex_stage_md (DATA_W=32): vector table, random ops vs arithmetic model, memory/reset sequences.
module tb_ex_stage_md;
    localparam int W = 32;

    logic        clk = 1'b0, resetn = 1'b0;
    logic        ds_to_es_valid = 1'b0, es_allow_in, ms_allow_in = 1'b1, es_to_ms_valid;
    logic [31:0] ds_pc = '0, ds_src1 = '0, ds_src2 = '0, ds_st_data = '0;
    logic [3:0]  ds_op = '0;
    logic        ds_mem_we = 1'b0, ds_res_from_mem = 1'b0, ds_gr_we = 1'b0;
    logic [1:0]  ds_mem_size = '0;
    logic [4:0]  ds_dest = '0;
    logic [31:0] es_to_ms_pc, es_to_ms_result, data_sram_addr, data_sram_wdata;
    logic        es_to_ms_res_from_mem, es_to_ms_gr_we, data_sram_en;
    logic [4:0]  es_to_ms_dest;
    logic [3:0]  data_sram_we;
`ifdef EX_ALE_EN
    logic        es_ex_ale;
`endif

    ex_stage_md #(.DATA_W(W), .DEST_W(5)) dut (
        .clk(clk), .resetn(resetn), .ds_to_es_valid(ds_to_es_valid), .es_allow_in(es_allow_in),
        .ms_allow_in(ms_allow_in), .es_to_ms_valid(es_to_ms_valid), .ds_pc(ds_pc),
        .ds_src1(ds_src1), .ds_src2(ds_src2), .ds_st_data(ds_st_data), .ds_op(ds_op),
        .ds_mem_we(ds_mem_we), .ds_res_from_mem(ds_res_from_mem), .ds_mem_size(ds_mem_size),
        .ds_dest(ds_dest), .ds_gr_we(ds_gr_we), .es_to_ms_pc(es_to_ms_pc),
        .es_to_ms_result(es_to_ms_result),
`ifdef EX_ALE_EN
        .es_ex_ale(es_ex_ale),
`endif
        .es_to_ms_res_from_mem(es_to_ms_res_from_mem), .es_to_ms_dest(es_to_ms_dest),
        .es_to_ms_gr_we(es_to_ms_gr_we), .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata)
    );

    always #5 clk = ~clk;

    int n_run = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference: plain language arithmetic on 64-bit values plus the divide-by-zero rule.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        logic [63:0] p;
        sa = $signed(a); sb = $signed(b); ua = a; ub = b;
        case (op)
            4'd1: begin p = ua * ub; return p[31:0]; end
            4'd2: begin p = sa * sb; return p[63:32]; end
            4'd3: begin p = ua * ub; return p[63:32]; end
            4'd4: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            4'd6: return (b == 0) ? a : 32'(sa % sb);
            4'd5: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            4'd7: return (b == 0) ? a : 32'(ua % ub);
            default: return a + b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [3:0] op);
        return (op >= 4 && op <= 7) ? W + 1 : 0;
    endfunction

    // Issue one ALU/div op, then measure edges from the latch edge until es_to_ms_valid.
    task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int k;
        logic saw_allow;
        logic [31:0] pc;
        logic [4:0] d;
        pc = $urandom; d = 5'($urandom);
        @(negedge clk);
        ds_to_es_valid = 1'b1; ds_op = op; ds_src1 = a; ds_src2 = b; ds_pc = pc; ds_dest = d;
        ds_gr_we = 1'b1; ds_mem_we = 1'b0; ds_res_from_mem = 1'b0;
        k = 0;
        while (!es_allow_in && k < 200) begin @(negedge clk); k++; end
        @(posedge clk); #1 ds_to_es_valid = 1'b0;
        @(negedge clk);
        k = 0; saw_allow = 1'b0;
        while (!es_to_ms_valid && k < 200) begin
            if (es_allow_in) saw_allow = 1'b1;
            @(negedge clk); k++;
        end
        chk({nm, " latency"}, 64'(k), 64'(exp_lat(op)));
        chk({nm, " result"}, {32'h0, es_to_ms_result}, {32'h0, exp});
        chk({nm, " pc/dest"}, {27'h0, es_to_ms_dest, es_to_ms_pc}, {27'h0, d, pc});
        if (exp_lat(op) != 0) chk({nm, " stall"}, {63'h0, saw_allow}, 64'h0);
    endtask

    // Memory access through the ADD path: address = (addr-0x10) + 0x10.
    task automatic mem_op(input string nm, input logic st, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] sd, input int stall, input logic [3:0] ewe,
                          input logic [31:0] ewd, input logic een, input logic eale);
        @(negedge clk);
        ms_allow_in = (stall == 0);
        ds_to_es_valid = 1'b1; ds_op = 4'd0; ds_src1 = addr - 32'h10; ds_src2 = 32'h10;
        ds_mem_we = st; ds_res_from_mem = ~st; ds_mem_size = sz; ds_st_data = sd; ds_gr_we = ~st;
        @(posedge clk); #1 ds_to_es_valid = 1'b0; ds_mem_we = 1'b0; ds_res_from_mem = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({nm, " we while stalled"}, {60'h0, data_sram_we}, 64'h0);
        end
        if (stall == 0) @(negedge clk);
        ms_allow_in = 1'b1;
        #1;
        chk({nm, " we"}, {60'h0, data_sram_we}, {60'h0, ewe});
        chk({nm, " en/addr"}, {31'h0, data_sram_en, data_sram_addr}, {31'h0, een, addr});
        if (st && ewe != 0) chk({nm, " wdata"}, {32'h0, data_sram_wdata}, {32'h0, ewd});
        if (!st) chk({nm, " res_from_mem"}, {63'h0, es_to_ms_res_from_mem}, 64'h1);
`ifdef EX_ALE_EN
        chk({nm, " ale"}, {63'h0, es_ex_ale}, {63'h0, eale});
`else
        if (eale) chk({nm, " aligned-down"}, {63'h0, es_to_ms_valid}, 64'h1);
`endif
        @(negedge clk);
        chk({nm, " we once"}, {60'h0, data_sram_we}, 64'h0);
    endtask

    typedef struct {
        string       nm;
        logic [3:0]  op;
        logic [31:0] a, b, exp;
    } vec_t;

    initial begin
        vec_t vt[$];
        logic [3:0] rop;
        logic [31:0] ra, rb;
        int k;

        vt.push_back('{"add ovf",   4'd0, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000});
        vt.push_back('{"mul",       4'd1, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000});
        vt.push_back('{"mulh",      4'd2, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF});
        vt.push_back('{"mulhu",     4'd3, 32'hFFFF_FFFF, 32'h2,         32'h0000_0001});
        vt.push_back('{"div -7/2",  4'd4, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD});
        vt.push_back('{"mod -7%2",  4'd6, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF});
        vt.push_back('{"divu /0",   4'd5, 32'h0000_1234, 32'h0,         32'hFFFF_FFFF});
        vt.push_back('{"mod /0",    4'd6, 32'h0000_1234, 32'h0,         32'h0000_1234});
        vt.push_back('{"div min",   4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
        vt.push_back('{"mod min",   4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0});
        vt.push_back('{"divu",      4'd5, 32'd100,       32'd7,         32'd14});
        vt.push_back('{"modu",      4'd7, 32'd100,       32'd7,         32'd2});
        vt.push_back('{"div 7/-2",  4'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD});
        vt.push_back('{"mod 7%-2",  4'd6, 32'd7,         32'hFFFF_FFFE, 32'd1});
        vt.push_back('{"div -5/0",  4'd4, 32'hFFFF_FFFB, 32'h0,         32'hFFFF_FFFF});
        vt.push_back('{"mod -5/0",  4'd6, 32'hFFFF_FFFB, 32'h0,         32'hFFFF_FFFB});
        vt.push_back('{"op9 add",   4'd9, 32'd5,         32'd6,         32'd11});

        #2;
        chk("reset allow/valid", {62'h0, es_allow_in, es_to_ms_valid}, 64'h2);
        chk("reset result/pc", {es_to_ms_result, es_to_ms_pc}, 64'h0);
        chk("reset sram", {27'h0, data_sram_en, data_sram_we, data_sram_addr}, 64'h0);
        chk("reset wdata/dest", {27'h0, es_to_ms_dest, data_sram_wdata}, 64'h0);
        @(negedge clk); resetn = 1'b1;

        foreach (vt[i]) run_op(vt[i].nm, vt[i].op, vt[i].a, vt[i].b, vt[i].exp);

        for (int i = 0; i < 30; i++) begin
            rop = 4'($urandom_range(0, 9));
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'h0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            run_op("random", rop, ra, rb, model(rop, ra, rb));
        end

        // Back-to-back divides: the second is latched on the edge the first leaves.
        @(negedge clk);
        ds_to_es_valid = 1'b1; ds_op = 4'd5; ds_src1 = 32'd1000; ds_src2 = 32'd9;
        @(posedge clk); #1 ds_op = 4'd7; ds_src1 = 32'd1000; ds_src2 = 32'd33;
        k = 0;
        @(negedge clk);
        while (!es_to_ms_valid && k < 200) begin @(negedge clk); k++; end
        chk("b2b first", {32'h0, es_to_ms_result}, {32'h0, model(4'd5, 32'd1000, 32'd9)});
        @(posedge clk); #1 ds_to_es_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (!es_to_ms_valid && k < 200) begin @(negedge clk); k++; end
        chk("b2b second latency", 64'(k), 64'(W + 1));
        chk("b2b second", {32'h0, es_to_ms_result}, {32'h0, model(4'd7, 32'd1000, 32'd33)});
        @(posedge clk);

        mem_op("sb 0x1003", 1'b1, 2'd0, 32'h1003, 32'hAB, 3, 4'b1000, 32'hABAB_ABAB, 1'b1, 1'b0);
        mem_op("sh 0x1002", 1'b1, 2'd1, 32'h1002, 32'h1234, 0, 4'b1100, 32'h1234_1234, 1'b1, 1'b0);
        mem_op("sw 0x1004", 1'b1, 2'd2, 32'h1004, 32'hDEAD_BEEF, 1, 4'b1111, 32'hDEAD_BEEF, 1'b1, 1'b0);
        mem_op("lb 0x1001", 1'b0, 2'd0, 32'h1001, 32'h0, 0, 4'b0000, 32'h0, 1'b1, 1'b0);
`ifdef EX_ALE_EN
        mem_op("sw 0x1002", 1'b1, 2'd2, 32'h1002, 32'h5555_AAAA, 0, 4'b0000, 32'h0, 1'b1, 1'b1);
        mem_op("lw 0x1001", 1'b0, 2'd2, 32'h1001, 32'h0, 0, 4'b0000, 32'h0, 1'b0, 1'b1);
`else
        mem_op("sw 0x1002", 1'b1, 2'd2, 32'h1002, 32'h5555_AAAA, 0, 4'b1111, 32'h5555_AAAA, 1'b1, 1'b1);
        mem_op("sh 0x1003", 1'b1, 2'd1, 32'h1003, 32'h00C3, 0, 4'b1100, 32'h00C3_00C3, 1'b1, 1'b1);
`endif

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        ds_to_es_valid = 1'b1; ds_op = 4'd4; ds_src1 = 32'd12345; ds_src2 = 32'd7;
        @(posedge clk); #1 ds_to_es_valid = 1'b0;
        repeat (10) @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        chk("midreset allow/valid", {62'h0, es_allow_in, es_to_ms_valid}, 64'h2);
        chk("midreset result", {32'h0, es_to_ms_result}, 64'h0);
        chk("midreset sram", {59'h0, data_sram_en, data_sram_we}, 64'h0);
        @(negedge clk); resetn = 1'b1;
        run_op("add after reset", 4'd0, 32'd3, 32'd4, 32'd7);
        run_op("div after reset", 4'd4, 32'd12345, 32'd7, 32'd1763);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
